// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result/flags stage after the CLA adder, two-entry skid buffer
// Ports: CLK/RST (sync, active-high); IN_VLD/IN_RDY + SUB, A_MSB, B_MSB, SUM, CARRY in;
// OUT_VLD/OUT_RDY + RES, FLAGS={Z,N,C,V} out; OVF_STKY sticky overflow.
module alu_result_stage #(
  parameter int DATA_WDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VLD,
  output logic                 IN_RDY,
  input  logic                 SUB,
  input  logic                 A_MSB,
  input  logic                 B_MSB,
  input  logic [DATA_WDTH-1:0] SUM,
  input  logic                 CARRY,
  output logic                 OUT_VLD,
  input  logic                 OUT_RDY,
  output logic [DATA_WDTH-1:0] RES,
  output logic [3:0]           FLAGS,
  output logic                 OVF_STKY
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t               state_q, state_d;
  logic                 in_rdy_q, in_rdy_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_WDTH+3:0] main_q, main_d, skid_q, skid_d, new_ent;
  logic                 accept, pop, n, v;
  always_comb begin
    n       = SUM[DATA_WDTH-1];
    // operand signs must agree for add, differ for sub; then overflow if result sign flips
    v       = ((A_MSB ^ B_MSB) == SUB) & (n ^ A_MSB);
    new_ent = {SUM, (SUM == '0), n, CARRY, v};
    accept  = IN_VLD & in_rdy_q;
    pop     = (state_q != EMPTY) & OUT_RDY;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        main_d  = new_ent;
      end
      ONE: if (accept & pop) main_d = new_ent;
      else if (accept) begin
        state_d = TWO;
        skid_d  = new_ent;
      end
      else if (pop) state_d = EMPTY;
      TWO: if (pop) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    in_rdy_d = state_d != TWO;
    ovf_d    = ovf_q | (accept & v);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= EMPTY;
      in_rdy_q <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= in_rdy_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      ovf_q    <= ovf_d;
    end
  end
  assign IN_RDY   = in_rdy_q;
  assign OUT_VLD  = state_q != EMPTY;
  assign RES      = main_q[DATA_WDTH+3:4];
  assign FLAGS    = main_q[3:0];
  assign OVF_STKY = ovf_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed vectors, stall/reset sequences and a random scoreboard run
module tb_alu_result_stage;
  logic        clk = 0, rst = 1, in_vld = 0, in_rdy, sub = 0, a_msb = 0, b_msb = 0;
  logic [31:0] sum = 0, res;
  logic        carry = 0, out_vld, out_rdy = 1, ovf;
  logic [3:0]  flags;
  int          total = 0, bad = 0;
  alu_result_stage #(.DATA_WDTH(32)) dut (
    .CLK(clk), .RST(rst), .IN_VLD(in_vld), .IN_RDY(in_rdy), .SUB(sub), .A_MSB(a_msb),
    .B_MSB(b_msb), .SUM(sum), .CARRY(carry), .OUT_VLD(out_vld), .OUT_RDY(out_rdy),
    .RES(res), .FLAGS(flags), .OVF_STKY(ovf)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        s, a, b;
    logic [31:0] sm;
    logic        c;
    logic [3:0]  fl;
  } vec_t;
  vec_t vt[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    sub = x.s; a_msb = x.a; b_msb = x.b; sum = x.sm; carry = x.c;
  endtask
  function automatic logic [3:0] ref_flags(input logic s, a, b, input logic [31:0] sm, input logic c);
    logic vv;
    if (s) vv = (a != b) && (sm[31] != a);
    else   vv = (a == b) && (sm[31] != a);
    return {sm == 32'd0, sm[31], c, vv};
  endfunction
  logic [35:0] q[$];
  initial begin
    logic        ovf_exp;
    logic [31:0] prev_res;
    logic [3:0]  prev_flags;
    logic        stalled, acc, pp;
    vec_t        r;
    vt[0] = '{0, 0, 0, 32'h00000002, 0, 4'b0000};
    vt[1] = '{0, 0, 0, 32'h80000000, 0, 4'b0101};
    vt[2] = '{1, 0, 0, 32'h00000000, 1, 4'b1010};
    vt[3] = '{1, 0, 0, 32'hFFFFFFFE, 0, 4'b0100};
    vt[4] = '{0, 1, 0, 32'h00000000, 1, 4'b1010};
    vt[5] = '{0, 1, 1, 32'h00000000, 1, 4'b1011};
    vt[6] = '{1, 1, 0, 32'h7FFFFFFF, 1, 4'b0011};
    vt[7] = '{1, 0, 1, 32'h80000000, 0, 4'b0101};
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_res", res, 0);
    chk("rst_flags", flags, 0);
    chk("rst_ovf", ovf, 0);
    ovf_exp = 0;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i]);
      in_vld = 1;
      @(negedge clk);
      in_vld = 0;
      ovf_exp |= vt[i].fl[0];
      chk($sformatf("vec%0d_vld", i), out_vld, 1);
      chk($sformatf("vec%0d_res", i), res, vt[i].sm);
      chk($sformatf("vec%0d_flags", i), flags, vt[i].fl);
      chk($sformatf("vec%0d_ovf", i), ovf, ovf_exp);
      @(negedge clk);
    end
    chk("idle_out_vld", out_vld, 0);
    for (int i = 0; i < 8; i++) begin
      sub = 0; a_msb = 0; b_msb = 0; carry = 0; sum = 100 + i; in_vld = 1;
      @(negedge clk);
      chk($sformatf("stream%0d_vld", i), out_vld, 1);
      chk($sformatf("stream%0d_res", i), res, 100 + i);
      chk($sformatf("stream%0d_rdy", i), in_rdy, 1);
    end
    in_vld = 0;
    @(negedge clk);
    chk("stream_drain", out_vld, 0);
    out_rdy = 0; in_vld = 1; sum = 32'hA1;
    @(negedge clk);
    chk("stall1_rdy", in_rdy, 1);
    sum = 32'hB2;
    @(negedge clk);
    chk("stall2_rdy", in_rdy, 0);
    chk("stall2_res", res, 32'hA1);
    sum = 32'hC3;
    @(negedge clk);
    chk("stall_ignore_res", res, 32'hA1);
    chk("stall_ignore_rdy", in_rdy, 0);
    in_vld = 0; out_rdy = 1;
    @(negedge clk);
    chk("drain1_res", res, 32'hB2);
    chk("drain1_vld", out_vld, 1);
    chk("drain1_rdy", in_rdy, 1);
    @(negedge clk);
    chk("drain2_vld", out_vld, 0);
    out_rdy = 0; in_vld = 1; drive(vt[1]);
    @(negedge clk);
    drive(vt[0]);
    @(negedge clk);
    chk("two_rdy", in_rdy, 0);
    chk("two_ovf", ovf, 1);
    rst = 1; sum = 32'h55;
    @(negedge clk);
    chk("rst2_out_vld", out_vld, 0);
    chk("rst2_in_rdy", in_rdy, 1);
    chk("rst2_res", res, 0);
    chk("rst2_flags", flags, 0);
    chk("rst2_ovf", ovf, 0);
    rst = 0; in_vld = 0;
    @(negedge clk);
    chk("rst2_nocap", out_vld, 0);
    stalled = 0; prev_res = 0; prev_flags = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      chk("rnd_out_vld", out_vld, q.size() > 0);
      chk("rnd_in_rdy", in_rdy, q.size() < 2);
      if (stalled) begin
        chk("rnd_hold_res", res, prev_res);
        chk("rnd_hold_flags", flags, prev_flags);
      end
      in_vld = $urandom_range(0, 1);
      out_rdy = $urandom_range(0, 3) != 0;
      r.s = $urandom_range(0, 1); r.a = $urandom_range(0, 1); r.b = $urandom_range(0, 1);
      r.c = $urandom_range(0, 1); r.sm = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      drive(r);
      acc = in_vld & in_rdy;
      pp = out_vld & out_rdy;
      if (pp) begin
        if (q.size() == 0) chk("rnd_underflow", 1, 0);
        else chk("rnd_data", {res, flags}, q.pop_front());
      end
      if (acc) q.push_back({r.sm, ref_flags(r.s, r.a, r.b, r.sm, r.c)});
      if (q.size() > 2) chk("rnd_overflow", q.size(), 2);
      stalled = out_vld & !out_rdy;
      prev_res = res; prev_flags = flags;
      @(negedge clk);
    end
    in_vld = 0; out_rdy = 1;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      if (out_vld) chk("drain_data", {res, flags}, q.pop_front());
      @(negedge clk);
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_out_vld", out_vld, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
